// File: rtl/uart_rx_deserializer_if.sv
// Byte-side handshake between the UART receive front end and its consumer.
// The receiver drives data/valid and the error pulses; the consumer drives ready.
interface uart_rx_deserializer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        output frame_err,
        output overrun
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: synchronises io_rxd, samples mid-bit, and hands each byte
// to the consumer over valid/ready, pulsing frame_err and overrun on faults.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | line idle, waiting for a falling edge on rxd_s
// ST_START | timing to mid start bit; a high sample there is a glitch
// ST_DATA  | sampling DATA_BITS data bits mid-bit, LSB first
// ST_STOP  | sampling the stop bit; low means framing error
// ST_BREAK | after a framing error, wait for the line to return high
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_rxd,
    uart_rx_deserializer_if.master   rx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS) + 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_clks
            $error("CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [IDX_W-1:0]     idx, idx_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic                 dlv_nx, fe_nx;
    logic                 dlv_pend;

    logic rxd_m, rxd_s, rxd_prev;

    // Synchroniser and edge-history flops reset high so a reset never looks like a start edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxd_m    <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_m    <= io_rxd;
            rxd_s    <= rxd_m;
            rxd_prev <= rxd_s;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            shreg <= shreg_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        shreg_nx = shreg;
        dlv_nx   = 1'b0;
        fe_nx    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rxd_prev && !rxd_s) begin
                    state_nx = ST_START;
                    cnt_nx   = '0;
                end
            end
            ST_START: begin
                if (cnt == CNT_HALF) begin
                    if (rxd_s) begin
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_DATA;
                        cnt_nx   = '0;
                        idx_nx   = '0;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt == CNT_FULL) begin
                    shreg_nx = {rxd_s, shreg[DATA_BITS-1:1]};
                    cnt_nx   = '0;
                    idx_nx   = idx + IDX_W'(1);
                    if (idx == IDX_LAST) begin
                        state_nx = ST_STOP;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_nx = '0;
                    if (rxd_s) begin
                        dlv_nx   = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        fe_nx    = 1'b1;
                        state_nx = ST_BREAK;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                if (rxd_s) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    logic accept;
    assign accept = rx.rx_valid & rx.rx_ready;

    // The assembled byte stays in shreg through the delivery cycle since IDLE never shifts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dlv_pend     <= 1'b0;
            rx.rx_data   <= '0;
            rx.rx_valid  <= 1'b0;
            rx.frame_err <= 1'b0;
            rx.overrun   <= 1'b0;
        end else begin
            dlv_pend     <= dlv_nx;
            rx.frame_err <= fe_nx;
            rx.overrun   <= 1'b0;
            if (dlv_pend) begin
                if (!rx.rx_valid || accept) begin
                    rx.rx_data  <= shreg;
                    rx.rx_valid <= 1'b1;
                end else begin
                    rx.overrun <= 1'b1;
                end
            end else if (accept) begin
                rx.rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: serial frames driven at 87 clk/bit,
// a passive recorder logs accepted bytes and pulses, each scenario checks inline.
module tb_uart_rx_deserializer;

    localparam int CPB = 87;
    localparam int DB  = 8;

    logic clock;
    logic reset;
    logic io_rxd;

    uart_rx_deserializer_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx_deserializer #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .io_rxd (io_rxd),
        .rx     (rx_if.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [DB-1:0] acc_q[$];
    int   fe_cnt    = 0;
    int   ov_cnt    = 0;
    int   vh_cnt    = 0;
    int   hold_viol = 0;
    logic prev_hold = 1'b0;
    logic [DB-1:0] prev_data = '0;

    always @(negedge clock) begin
        if (reset) begin
            if (rx_if.rx_valid && rx_if.rx_ready) acc_q.push_back(rx_if.rx_data);
            if (rx_if.frame_err) fe_cnt++;
            if (rx_if.overrun) ov_cnt++;
            if (rx_if.rx_valid) vh_cnt++;
            if (prev_hold && (!rx_if.rx_valid || rx_if.rx_data !== prev_data)) hold_viol++;
            prev_hold = rx_if.rx_valid && !rx_if.rx_ready;
            prev_data = rx_if.rx_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic idle_bits(input int n);
        io_rxd = 1'b1;
        repeat (n * CPB) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clock);
        io_rxd = b;
        repeat (CPB - 1) @(negedge clock);
    endtask

    task automatic send_byte(input logic [DB-1:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        send_bit(stop_bit);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clock);
        #1 rx_if.rx_ready = r;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        io_rxd = 1'b1;
        rx_if.rx_ready = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_out: valid=%b data=%h expected valid=0 data=00", rx_if.rx_valid, rx_if.rx_data);
        end
        checks++;
        if (rx_if.frame_err !== 1'b0 || rx_if.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: frame_err=%b overrun=%b expected 0 0", rx_if.frame_err, rx_if.overrun);
        end
        reset = 1'b1;
        idle_bits(1);
    endtask

    task automatic test_single();
        int base = acc_q.size();
        int fe0 = fe_cnt, ov0 = ov_cnt, vh0 = vh_cnt;
        send_byte(8'h55, 1'b1);
        idle_bits(2);
        checks++;
        if (acc_q.size() - base != 1) begin
            errors++;
            $display("FAIL single_count: got %0d beats expected 1", acc_q.size() - base);
        end else begin
            checks++;
            if (acc_q[base] !== 8'h55) begin
                errors++;
                $display("FAIL single_data: got %h expected 55", acc_q[base]);
            end
        end
        checks++;
        if (vh_cnt - vh0 != 1) begin
            errors++;
            $display("FAIL single_valid_len: got %0d cycles expected 1", vh_cnt - vh0);
        end
        checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL single_pulses: frame_err %0d overrun %0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    task automatic test_back_to_back();
        int base = acc_q.size();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        idle_bits(2);
        checks++;
        if (acc_q.size() - base != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats expected 2", acc_q.size() - base);
        end else begin
            checks++;
            if (acc_q[base] !== 8'hA5) begin
                errors++;
                $display("FAIL b2b_first: got %h expected a5", acc_q[base]);
            end
            checks++;
            if (acc_q[base+1] !== 8'h3C) begin
                errors++;
                $display("FAIL b2b_second: got %h expected 3c", acc_q[base+1]);
            end
        end
    endtask

    task automatic test_glitch();
        int base = acc_q.size();
        int vh0 = vh_cnt, fe0 = fe_cnt;
        @(negedge clock);
        io_rxd = 1'b0;
        repeat (20) @(negedge clock);
        io_rxd = 1'b1;
        repeat (200) @(negedge clock);
        checks++;
        if (vh_cnt != vh0 || acc_q.size() != base || fe_cnt != fe0) begin
            errors++;
            $display("FAIL glitch_quiet: valid cycles %0d beats %0d frame_err %0d expected 0 0 0",
                     vh_cnt - vh0, acc_q.size() - base, fe_cnt - fe0);
        end
        send_byte(8'hE7, 1'b1);
        idle_bits(2);
        checks++;
        if (acc_q.size() - base != 1 || acc_q[acc_q.size()-1] !== 8'hE7) begin
            errors++;
            $display("FAIL glitch_recover: beats %0d last %h expected 1 e7", acc_q.size() - base,
                     (acc_q.size() > 0) ? acc_q[acc_q.size()-1] : 8'hxx);
        end
    endtask

    task automatic test_frame_err();
        int base = acc_q.size();
        int fe0 = fe_cnt;
        send_byte(8'h81, 1'b0);
        repeat (200) @(negedge clock);
        io_rxd = 1'b1;
        idle_bits(2);
        checks++;
        if (fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL ferr_pulse: got %0d pulses expected 1", fe_cnt - fe0);
        end
        checks++;
        if (acc_q.size() != base) begin
            errors++;
            $display("FAIL ferr_discard: got %0d beats expected 0", acc_q.size() - base);
        end
        send_byte(8'h12, 1'b1);
        idle_bits(2);
        checks++;
        if (acc_q.size() - base != 1 || acc_q[acc_q.size()-1] !== 8'h12) begin
            errors++;
            $display("FAIL ferr_next: beats %0d last %h expected 1 12", acc_q.size() - base,
                     (acc_q.size() > 0) ? acc_q[acc_q.size()-1] : 8'hxx);
        end
        checks++;
        if (fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL ferr_single: got %0d pulses expected 1", fe_cnt - fe0);
        end
    endtask

    task automatic test_overrun();
        int base = acc_q.size();
        int ov0 = ov_cnt, hv0 = hold_viol;
        set_ready(1'b0);
        send_byte(8'h11, 1'b1);
        idle_bits(1);
        send_byte(8'h22, 1'b1);
        idle_bits(2);
        checks++;
        if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h11) begin
            errors++;
            $display("FAIL ovr_hold: valid=%b data=%h expected 1 11", rx_if.rx_valid, rx_if.rx_data);
        end
        checks++;
        if (ov_cnt - ov0 != 1) begin
            errors++;
            $display("FAIL ovr_pulse: got %0d pulses expected 1", ov_cnt - ov0);
        end
        checks++;
        if (hold_viol != hv0) begin
            errors++;
            $display("FAIL ovr_stable: got %0d changes while stalled expected 0", hold_viol - hv0);
        end
        set_ready(1'b1);
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (rx_if.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_drain_valid: got %b expected 0", rx_if.rx_valid);
        end
        checks++;
        if (acc_q.size() - base != 1 || acc_q[acc_q.size()-1] !== 8'h11) begin
            errors++;
            $display("FAIL ovr_accept: beats %0d last %h expected 1 11", acc_q.size() - base,
                     (acc_q.size() > 0) ? acc_q[acc_q.size()-1] : 8'hxx);
        end
    endtask

    task automatic test_mid_reset();
        logic [DB-1:0] d;
        int base;
        int fe0;
        d = 8'h6B;
        set_ready(1'b0);
        send_byte(8'h5A, 1'b1);
        idle_bits(1);
        checks++;
        if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h5A) begin
            errors++;
            $display("FAIL mrst_pre: valid=%b data=%h expected 1 5a", rx_if.rx_valid, rx_if.rx_data);
        end
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        @(negedge clock);
        io_rxd = d[4];
        repeat (43) @(negedge clock);
        #3 reset = 1'b0;
        #1;
        checks++;
        if (rx_if.rx_valid !== 1'b0 || rx_if.rx_data !== 8'h00 ||
            rx_if.frame_err !== 1'b0 || rx_if.overrun !== 1'b0) begin
            errors++;
            $display("FAIL mrst_clear: valid=%b data=%h ferr=%b ovr=%b expected 0 00 0 0",
                     rx_if.rx_valid, rx_if.rx_data, rx_if.frame_err, rx_if.overrun);
        end
        io_rxd = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        set_ready(1'b1);
        idle_bits(2);
        base = acc_q.size();
        fe0 = fe_cnt;
        send_byte(8'hC3, 1'b1);
        idle_bits(2);
        checks++;
        if (acc_q.size() - base != 1 || acc_q[acc_q.size()-1] !== 8'hC3) begin
            errors++;
            $display("FAIL mrst_after: beats %0d last %h expected 1 c3", acc_q.size() - base,
                     (acc_q.size() > 0) ? acc_q[acc_q.size()-1] : 8'hxx);
        end
        checks++;
        if (fe_cnt != fe0) begin
            errors++;
            $display("FAIL mrst_ferr: got %0d pulses expected 0", fe_cnt - fe0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
